// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: shared state encoding and default widths for the RAM burst controller.
package ram_burst_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: 2-entry FIFO absorbing RAM read data while the consumer stalls.
module ram_rd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign head = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: write/read burst controller in front of a single-port synchronous RAM.
// Define RAM_BURST_CTRL_NOWRAP_EN to truncate bursts at the top address and flag them on err.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_BURST_CTRL_NOWRAP_EN
  ,output logic             err
`endif
);
  state_t state, nxt;
  logic [ADDR_W-1:0] cur_addr, beats;
  logic issued_all, inflight;
  logic [1:0] count;
  logic [DATA_W-1:0] head;
  logic accept, wfire, pop, issue, last, done;

  assign accept = cmd_valid && state == IDLE;
  assign wfire = state == WRITE && wr_valid;
  assign pop = rd_valid && rd_ready;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
  assign last = beats == '0 || &cur_addr;
`else
  assign last = beats == '0;
`endif
  // Occupancy once the in-flight beat lands must leave room for this issue.
  assign issue = state == READ && !issued_all && ({1'b0, count} + 3'(inflight) < 3'd2 + 3'(pop));
  assign done = (wfire && last) || (state == READ && issued_all && !inflight && count == 2'd1 && pop);

  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wr_ready = state == WRITE;
  assign ram_we = wfire;
  assign ram_addr = state == IDLE ? '0 : cur_addr;
  assign ram_din = wfire ? wr_data : '0;
  assign rd_valid = state == READ && count != 2'd0;
  assign rd_data = head;

  always_comb nxt = accept ? (cmd_rd ? READ : WRITE) : done ? IDLE : state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
      beats <= '0;
      issued_all <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        cur_addr <= cmd_addr;
        beats <= cmd_len;
        issued_all <= 1'b0;
      end else if (wfire || issue) begin
        cur_addr <= cur_addr + 1'b1;
        beats <= beats - 1'b1;
        if (issue && last) issued_all <= 1'b1;
      end
    end
  end

`ifdef RAM_BURST_CTRL_NOWRAP_EN
  logic trunc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trunc <= 1'b0;
      err <= 1'b0;
    end else begin
      if (accept) trunc <= ((ADDR_W+1)'(cmd_addr) + (ADDR_W+1)'(cmd_len)) > (ADDR_W+1)'((1 << ADDR_W) - 1);
      err <= done && trunc;
    end
  end
`endif

  ram_rd_skid #(.W(DATA_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .push_data(ram_dout),
    .pop(pop),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bursts against a behavioural 16x8 RAM with a read-data scoreboard.
module tb_ram_burst_ctrl;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_rd = 0;
  logic [3:0] cmd_addr = 0, cmd_len = 0;
  logic wr_valid = 0, wr_ready;
  logic [7:0] wr_data = 0;
  logic rd_valid, rd_ready = 0;
  logic [7:0] rd_data;
  logic busy, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [16];
  logic [7:0] sh [16];
  bit known [16];
  logic [7:0] wd [16];
  logic [7:0] exp_q [$];
  logic [7:0] old6;
  int pass_cnt = 0, total = 0;

`ifdef RAM_BURST_CTRL_NOWRAP_EN
  localparam bit NOWRAP = 1;
  logic err;
  int err_cnt = 0;
  always @(negedge clk) if (err) err_cnt++;
`else
  localparam bit NOWRAP = 0;
  int err_cnt = 0;
`endif

  ram_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rd_unexpected: got %0h expected no beat", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  function automatic int nbeats(input logic [3:0] a, input logic [3:0] l);
    return (NOWRAP && int'(a) + int'(l) > 15) ? 16 - int'(a) : int'(l) + 1;
  endfunction

  function automatic bit truncd(input logic [3:0] a, input logic [3:0] l);
    return NOWRAP && int'(a) + int'(l) > 15;
  endfunction

  task automatic send_cmd(input logic rd, input logic [3:0] a, input logic [3:0] l);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_rd = rd; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) begin
      $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 20 cycles");
      $fatal(1);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic check_ram();
    for (int j = 0; j < 16; j++)
      if (known[j]) chk($sformatf("ram[%0d]", j), mem[j], sh[j]);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] l);
    int n, e, k;
    bit stop;
    e = nbeats(a, l); n = 0; stop = 0; k = err_cnt;
    send_cmd(0, a, l);
    for (int i = 0; i <= int'(l) && !stop; i++) begin
      wr_valid = 1; wr_data = wd[i];
      @(negedge clk);
      if (!wr_ready) stop = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    wr_valid = 0;
    chk("wr_beats", n, e);
    if (!stop) @(negedge clk);
    chk("wr_cmd_ready", cmd_ready, 1);
    chk("wr_busy", busy, 0);
    @(posedge clk); #1;
    chk("wr_err_pulses", err_cnt - k, truncd(a, l));
    for (int i = 0; i < e; i++) begin
      sh[(int'(a) + i) % 16] = wd[i];
      known[(int'(a) + i) % 16] = 1;
    end
    check_ram();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int mode);
    int n, got, k, done_c;
    bit fin;
    n = nbeats(a, l); got = 0; fin = 0; k = err_cnt; done_c = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(sh[(int'(a) + i) % 16]);
    send_cmd(1, a, l);
    for (int c = 1; c < 200 && !fin; c++) begin
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 1 || c % 4 == 0) : (c > 8);
      @(negedge clk);
      if (mode == 0 && rd_valid && rd_ready) begin
        chk("rd_beat_cycle", c, got + 3);
        got++;
      end
      if (cmd_ready) begin
        fin = 1;
        done_c = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("rd_completed", fin, 1);
    chk("rd_all_delivered", exp_q.size(), 0);
    chk("rd_busy_at_idle", busy, 0);
    if (mode == 0) chk("rd_idle_cycle", done_c, n + 3);
    @(posedge clk); #1;
    rd_ready = 0;
    chk("rd_err_pulses", err_cnt - k, truncd(a, l));
    exp_q.delete();
  endtask

  initial begin
    for (int j = 0; j < 16; j++) known[j] = 0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rd_data", rd_data, 0);
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    chk("rst_err", err, 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    wd[0] = 8'h81; wd[1] = 8'hEA; wd[2] = 8'hFF;
    do_write(4'h0, 4'h2);
    do_read(4'h0, 4'h2, 0);
    do_read(4'h0, 4'h2, 1);

    wd[0] = 8'h11; wd[1] = 8'h22;
    do_write(4'hF, 4'h1);
    do_read(4'hF, 4'h1, 0);

    old6 = mem[6];
    send_cmd(0, 4'h4, 4'h3);
    wr_valid = 1; wr_data = 8'hA1;
    @(posedge clk); #1;
    wr_data = 8'hA2;
    @(posedge clk); #1;
    wr_data = 8'hA3;
    rst = 1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_din", ram_din, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    wr_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    sh[4] = 8'hA1; known[4] = 1;
    sh[5] = 8'hA2; known[5] = 1;
    check_ram();
    chk("mid_rst_ram6_untouched", mem[6], old6);
    do_read(4'h4, 4'h1, 0);

    for (int i = 0; i < 16; i++) wd[i] = 8'(i);
    do_write(4'h3, 4'hF);
    do_read(4'h3, 4'hF, 2);
    do_read(4'h3, 4'hF, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
